// File: rtl/mips_pkg.sv
// Shared MIPS multicycle definitions: state codes, opcode/funct
// constants and the ALU control encodings used by the ALU.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ALU control decode with a legality flag.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] aluControl,
    output logic       legal
);

    always_comb begin
        aluControl = ALU_ADD;
        legal      = 1'b1;
        case (funct)
            F_ADD:   aluControl = ALU_ADD;
            F_SUB:   aluControl = ALU_SUB;
            F_AND:   aluControl = ALU_AND;
            F_OR:    aluControl = ALU_OR;
            F_SLT:   aluControl = ALU_SLT;
            F_NOR:   aluControl = ALU_NOR;
            default: legal      = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM (Moore). Define MC_CONTROL_BNE_EN
// to add bne support through the BRANCH state.
module mc_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zeroFlag,
    output logic [3:0] aluControl,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSrc,
    output logic       pcWrite,
    output logic       iorD,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       illegalOp,
    output logic [3:0] state
);

    state_t     cur;
    state_t     nxt;
    logic [3:0] dec_alu;
    logic       dec_legal;
    logic       bad_op;
    logic       br_take;

    alu_decoder u_alu_decoder (
        .funct      (funct),
        .aluControl (dec_alu),
        .legal      (dec_legal)
    );

    always_comb begin
        nxt    = S_FETCH;
        bad_op = 1'b0;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEMADR;
                    OP_BEQ:       nxt = S_BRANCH;
`ifdef MC_CONTROL_BNE_EN
                    OP_BNE:       nxt = S_BRANCH;
`endif
                    OP_ADDI:      nxt = S_ADDIEX;
                    OP_J:         nxt = S_JUMP;
                    OP_RTYPE: begin
                        nxt    = dec_legal ? S_EXECUTE : S_FETCH;
                        bad_op = !dec_legal;
                    end
                    default:      bad_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW)
                    nxt = S_MEMRD;
                else if (opcode == OP_SW)
                    nxt = S_MEMWR;
            end
            S_MEMRD:   nxt = S_MEMWB;
            S_EXECUTE: nxt = S_ALUWB;
            S_ADDIEX:  nxt = S_ADDIWB;
            default:   nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= S_FETCH;
            illegalOp <= 1'b0;
        end else begin
            cur <= nxt;
            if (bad_op)
                illegalOp <= 1'b1;
        end
    end

`ifdef MC_CONTROL_BNE_EN
    assign br_take = (opcode == OP_BNE) ? !zeroFlag : zeroFlag;
`else
    assign br_take = zeroFlag;
`endif

    // Reset overrides the FETCH decode so nothing is enabled while held
    always_comb begin
        aluControl = ALU_ADD;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        pcSrc      = 2'b00;
        pcWrite    = 1'b0;
        iorD       = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regDst     = 1'b0;
        memToReg   = 1'b0;
        regWrite   = 1'b0;
        if (!reset) begin
            case (cur)
                S_FETCH: begin
                    irWrite = 1'b1;
                    aluSrcB = 2'b01;
                    pcWrite = 1'b1;
                end
                S_DECODE: aluSrcB = 2'b11;
                S_MEMADR, S_ADDIEX: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                end
                S_MEMRD: iorD = 1'b1;
                S_MEMWB: begin
                    memToReg = 1'b1;
                    regWrite = 1'b1;
                end
                S_MEMWR: begin
                    iorD     = 1'b1;
                    memWrite = 1'b1;
                end
                S_EXECUTE: begin
                    aluSrcA    = 1'b1;
                    aluControl = dec_alu;
                end
                S_ALUWB: begin
                    regDst   = 1'b1;
                    regWrite = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA    = 1'b1;
                    aluControl = ALU_SUB;
                    pcSrc      = 2'b01;
                    pcWrite    = br_take;
                end
                S_ADDIWB: regWrite = 1'b1;
                S_JUMP: begin
                    pcSrc   = 2'b10;
                    pcWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-cycle expected state/outputs.
module tb_mc_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zeroFlag;
    logic [3:0] aluControl;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic       pcWrite, iorD, memWrite, irWrite;
    logic       regDst, memToReg, regWrite;
    logic       illegalOp;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic ill_exp = 1'b0;

    mc_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zeroFlag   (zeroFlag),
        .aluControl (aluControl),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .pcSrc      (pcSrc),
        .pcWrite    (pcWrite),
        .iorD       (iorD),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .regDst     (regDst),
        .memToReg   (memToReg),
        .regWrite   (regWrite),
        .illegalOp  (illegalOp),
        .state      (state)
    );

    always #5 clk = ~clk;

    wire [16:0] dut_vec = {aluControl, aluSrcA, aluSrcB, pcSrc,
                           pcWrite, iorD, memWrite, irWrite,
                           regDst, memToReg, regWrite, illegalOp};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // {alu, srcA, srcB, pcSrc, pcW, iorD, memW, irW, regDst, m2r, regW, ill}
    function automatic logic [16:0] exp_out(input logic [3:0] st,
        input logic [3:0] alu_ex, input logic pcw, input logic ill);
        case (st)
            4'd0:  return {4'b0010, 1'b0, 2'b01, 2'b00, 7'b1001000, ill};
            4'd1:  return {4'b0010, 1'b0, 2'b11, 2'b00, 7'b0000000, ill};
            4'd2:  return {4'b0010, 1'b1, 2'b10, 2'b00, 7'b0000000, ill};
            4'd3:  return {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0100000, ill};
            4'd4:  return {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0000011, ill};
            4'd5:  return {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0110000, ill};
            4'd6:  return {alu_ex,  1'b1, 2'b00, 2'b00, 7'b0000000, ill};
            4'd7:  return {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0000101, ill};
            4'd8:  return {4'b0110, 1'b1, 2'b00, 2'b01, pcw, 6'b000000, ill};
            4'd9:  return {4'b0010, 1'b1, 2'b10, 2'b00, 7'b0000000, ill};
            4'd10: return {4'b0010, 1'b0, 2'b00, 2'b00, 7'b0000001, ill};
            default: return {4'b0010, 1'b0, 2'b00, 2'b10, 7'b1000000, ill};
        endcase
    endfunction

    // Called just after a negedge with the DUT in FETCH
    task automatic run(input logic [5:0] op, input logic [5:0] fn,
                       input logic zf, input string tag);
        logic [3:0] seq[$];
        logic [3:0] alu_ex;
        logic       fn_ok, illegal, pcw, ill_now;
        exp_t       e;
        opcode   = op;
        funct    = fn;
        zeroFlag = zf;
        fn_ok = 1'b1;
        alu_ex = 4'b0010;
        case (fn)
            6'h20: alu_ex = 4'b0010;
            6'h22: alu_ex = 4'b0110;
            6'h24: alu_ex = 4'b0000;
            6'h25: alu_ex = 4'b0001;
            6'h2a: alu_ex = 4'b0111;
            6'h27: alu_ex = 4'b1100;
            default: fn_ok = 1'b0;
        endcase
        illegal = 1'b0;
        pcw = zf;
        case (op)
            6'h23: seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
            6'h2b: seq = '{4'd0, 4'd1, 4'd2, 4'd5};
            6'h00: begin
                if (fn_ok) seq = '{4'd0, 4'd1, 4'd6, 4'd7};
                else begin seq = '{4'd0, 4'd1}; illegal = 1'b1; end
            end
            6'h04: seq = '{4'd0, 4'd1, 4'd8};
            6'h08: seq = '{4'd0, 4'd1, 4'd9, 4'd10};
            6'h02: seq = '{4'd0, 4'd1, 4'd11};
`ifdef MC_CONTROL_BNE_EN
            6'h05: begin seq = '{4'd0, 4'd1, 4'd8}; pcw = !zf; end
`endif
            default: begin seq = '{4'd0, 4'd1}; illegal = 1'b1; end
        endcase
        ill_now = ill_exp;
        foreach (seq[i]) begin
            e.st  = seq[i];
            e.vec = exp_out(seq[i], alu_ex, pcw, ill_now);
            exp_q.push_back(e);
            if (seq[i] == 4'd1 && illegal) ill_now = 1'b1;
        end
        ill_exp = ill_now;
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            check({tag, ".state"}, {28'd0, state}, {28'd0, e.st});
            check({tag, ".outs"}, {15'd0, dut_vec}, {15'd0, e.vec});
            @(negedge clk);
        end
    endtask

    logic [5:0] ops[8];
    logic [5:0] fns[7];

    initial begin
        ops = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02, 6'h05, 6'h3f};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h11};
        reset = 1'b1;
        opcode = 6'h00;
        funct = 6'h20;
        zeroFlag = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst.state", {28'd0, state}, 32'd0);
        check("rst.outs", {15'd0, dut_vec}, {15'd0, 4'b0010, 13'd0});
        @(negedge clk);
        reset = 1'b0;

        run(OP_LW,    6'h00, 1'b0, "lw");
        run(OP_SW,    6'h00, 1'b0, "sw");
        run(OP_RTYPE, F_SLT, 1'b0, "slt");
        run(OP_RTYPE, F_NOR, 1'b0, "nor");
        run(OP_RTYPE, F_SUB, 1'b1, "sub");
        run(OP_BEQ,   6'h00, 1'b1, "beq_t");
        run(OP_BEQ,   6'h00, 1'b0, "beq_n");
        run(OP_ADDI,  6'h00, 1'b0, "addi");
        run(OP_J,     6'h00, 1'b0, "j");
        run(OP_BNE,   6'h00, 1'b0, "bne0");
        run(OP_BNE,   6'h00, 1'b1, "bne1");
        run(6'h3f,    6'h00, 1'b0, "ill");
        run(OP_LW,    6'h00, 1'b0, "lw_ill");

        opcode = OP_RTYPE;
        funct = F_ADD;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mid.state", {28'd0, state}, 32'd6);
        #1;
        reset = 1'b1;
        #1;
        check("rst2.state", {28'd0, state}, 32'd0);
        check("rst2.outs", {15'd0, dut_vec}, {15'd0, 4'b0010, 13'd0});
        ill_exp = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post.state", {28'd0, state}, 32'd0);
        check("post.pcW_irW", {30'd0, pcWrite, irWrite}, 32'd3);

        run(OP_J,     6'h00, 1'b0, "j2");
        run(OP_RTYPE, 6'h11, 1'b0, "badfn");
        run(OP_SW,    6'h00, 1'b0, "sw_ill");

        for (int k = 0; k < 20; k++) begin
            run(ops[$urandom_range(7)], fns[$urandom_range(6)],
                1'($urandom_range(1)), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
